// File: rtl/sync_core_matrix_pkg.sv
// Shared types and helpers for the coupled phase-oscillator matrix.
// Holds the FSM state enum, upper-triangle weight indexing and coupling decode.
package core_matrix_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int CLAMP_LO = 1;

  // Flat index of pair (i,j), i<j, in the packed upper triangle
  function automatic int weight_index(int n, int i, int j);
    return n * i - (i * (i + 1)) / 2 + j - i - 1;
  endfunction

  function automatic int coupling(int code, int num_weights);
    if (code >= num_weights) return 0;
    return code - (num_weights - 1) / 2;
  endfunction

  function automatic int clamp_hi(int p);
    return (1 << (p - 1)) - 1;
  endfunction

endpackage

// File: rtl/sync_core_matrix_if.sv
// Config write and result handshake bundle for sync_core_matrix.
// master = host/readout side, slave = the oscillator matrix.
interface sync_core_matrix_if #(
  parameter int N      = 3,
  parameter int ADDR_W = 3,
  parameter int DATA_W = 8
);
  logic              cfg_valid;
  logic              cfg_ready;
  logic [ADDR_W-1:0] cfg_addr;
  logic [DATA_W-1:0] cfg_data;
  logic [N-1:0]      result;
  logic              result_valid;
  logic              result_ready;

  modport master (
    output cfg_valid, cfg_addr, cfg_data, result_ready,
    input  cfg_ready, result, result_valid
  );

  modport slave (
    input  cfg_valid, cfg_addr, cfg_data, result_ready,
    output cfg_ready, result, result_valid
  );
endinterface

// File: rtl/sync_core_matrix_spin_cell.sv
// One phase accumulator: weighted sign-coupling sum, clamp, and wrap-around update.
// The own slot of the row contributes nothing since its phase difference is always zero.
module sync_spin_cell
  import core_matrix_pkg::*;
#(
  parameter int N           = 3,
  parameter int NUM_WEIGHTS = 5,
  parameter int P           = 8,
  parameter int BASE_STEP   = 16,
  parameter int IDX         = 0,
  localparam int WB         = $clog2(NUM_WEIGHTS),
  localparam int SW         = P + $clog2(N * NUM_WEIGHTS) + 2
) (
  input  logic           clk,
  input  logic           rstn,
  input  logic           load,
  input  logic           step_en,
  input  logic           noise_on,
  input  logic           noise_bit,
  input  logic [P-1:0]   init_phase,
  input  logic [N*P-1:0] phases_all,
  input  logic [N*WB-1:0] row,
  output logic [P-1:0]   phase,
  output logic           nxt_msb
);

  localparam logic signed [SW-1:0] BASE = SW'(BASE_STEP);
  localparam logic signed [SW-1:0] LO   = SW'(CLAMP_LO);
  localparam logic signed [SW-1:0] HI   = SW'(clamp_hi(P));
  localparam logic signed [SW-1:0] ONE  = SW'(1);

  logic [P-1:0]           cur;
  logic [P-1:0]           d;
  logic signed [SW-1:0]   c;
  logic signed [SW-1:0]   sum;
  logic [P-1:0]           step;
  logic [P-1:0]           phase_nxt;

  assign cur = phases_all[IDX*P +: P];

  always_comb begin
    sum = BASE;
    d   = '0;
    c   = '0;
    for (int j = 0; j < N; j++) begin
      d = phases_all[j*P +: P] - cur;
      c = SW'(coupling(int'(row[j*WB +: WB]), NUM_WEIGHTS));
      if (d != '0) sum = d[P-1] ? sum - c : sum + c;
    end
    if (noise_on) sum = noise_bit ? sum + ONE : sum - ONE;
    if (sum < LO)      step = LO[P-1:0];
    else if (sum > HI) step = HI[P-1:0];
    else               step = sum[P-1:0];
    phase_nxt = cur + step;
  end

  assign nxt_msb = phase_nxt[P-1];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)        phase <= '0;
    else if (load)    phase <= init_phase;
    else if (step_en) phase <= phase_nxt;
  end

endmodule

// File: rtl/sync_core_matrix.sv
// Clocked all-to-all coupled phase-oscillator matrix with run FSM, config regs and result handshake.
// Optional build macro CORE_MATRIX_NOISE_EN adds LFSR dither during the first half of a run.
//
// state | meaning
// IDLE  | config writes accepted, waiting for start
// RUN   | all spins step once per cycle, counter counts down
// DONE  | result held valid until consumed or aborted
module sync_core_matrix
  import core_matrix_pkg::*;
#(
  parameter int N           = 3,
  parameter int NUM_WEIGHTS = 5,
  parameter int PHASE_BITS  = 8,
  parameter int BASE_STEP   = 16,
  parameter int RUN_BITS    = 16
) (
  input  logic                    clk,
  input  logic                    rstn,
  sync_core_matrix_if.slave       bus,
  input  logic                    start,
  input  logic                    abort,
  input  logic [RUN_BITS-1:0]     run_cycles,
  output logic                    busy,
  output logic [N-1:0]            spins,
  output logic [N*PHASE_BITS-1:0] phases
);

  localparam int P  = PHASE_BITS;
  localparam int NW = N * (N - 1) / 2;
  localparam int WB = $clog2(NUM_WEIGHTS);

  state_t              state, nstate;
  logic [RUN_BITS-1:0] cnt;
  logic                load, step_en, cfg_fire;
  logic [NW*WB-1:0]    weights;
  logic [N*P-1:0]      init_ph;
  logic [N-1:0]        init_msb, nxt_msb;
  logic [N-1:0]        result_q;
  logic                rv_q;
  logic                noise_on;
  logic [N-1:0]        noise_bits;
  logic [N*WB-1:0]     row [N];

  assign busy          = (state != IDLE);
  assign bus.cfg_ready = (state == IDLE) && !start;
  assign bus.result    = result_q;
  assign bus.result_valid = rv_q;
  assign cfg_fire      = bus.cfg_valid && bus.cfg_ready;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      weights <= '0;
      init_ph <= '0;
    end else if (cfg_fire) begin
      if (int'(bus.cfg_addr) < NW)
        weights[int'(bus.cfg_addr)*WB +: WB] <= bus.cfg_data[WB-1:0];
      else if (int'(bus.cfg_addr) < NW + N)
        init_ph[(int'(bus.cfg_addr)-NW)*P +: P] <= bus.cfg_data[P-1:0];
    end
  end

  always_comb begin
    nstate  = state;
    load    = 1'b0;
    step_en = 1'b0;
    case (state)
      IDLE: if (start && !abort) begin
        load   = 1'b1;
        nstate = (run_cycles == '0) ? DONE : RUN;
      end
      RUN: begin
        if (abort) nstate = IDLE;
        else begin
          step_en = 1'b1;
          if (cnt == RUN_BITS'(1)) nstate = DONE;
        end
      end
      DONE: if (abort || (rv_q && bus.result_ready)) nstate = IDLE;
      default: nstate = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= IDLE;
      cnt      <= '0;
      result_q <= '0;
      rv_q     <= 1'b0;
    end else begin
      state <= nstate;
      rv_q  <= (nstate == DONE);
      if (load)         cnt <= run_cycles;
      else if (step_en) cnt <= cnt - RUN_BITS'(1);
      if (load && run_cycles == '0)            result_q <= init_msb;
      else if (step_en && cnt == RUN_BITS'(1)) result_q <= nxt_msb;
    end
  end

`ifdef CORE_MATRIX_NOISE_EN
  logic [15:0]         lfsr;
  logic [RUN_BITS-1:0] run_len;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      lfsr    <= 16'hACE1;
      run_len <= '0;
    end else begin
      if (load) run_len <= run_cycles;
      if (state == RUN) lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
    end
  end

  assign noise_on = (state == RUN) && (cnt > (run_len >> 1));
  for (genvar i = 0; i < N; i++) begin : g_noise
    assign noise_bits[i] = lfsr[i % 16];
  end
`else
  assign noise_on   = 1'b0;
  assign noise_bits = '0;
`endif

  for (genvar i = 0; i < N; i++) begin : g_spin
    for (genvar j = 0; j < N; j++) begin : g_row
      if (i == j) begin : g_self
        assign row[i][j*WB +: WB] = '0;
      end else begin : g_pair
        localparam int WI = weight_index(N, (i < j) ? i : j, (i < j) ? j : i);
        assign row[i][j*WB +: WB] = weights[WI*WB +: WB];
      end
    end

    sync_spin_cell #(
      .N(N), .NUM_WEIGHTS(NUM_WEIGHTS), .P(P), .BASE_STEP(BASE_STEP), .IDX(i)
    ) u_cell (
      .clk        (clk),
      .rstn       (rstn),
      .load       (load),
      .step_en    (step_en),
      .noise_on   (noise_on),
      .noise_bit  (noise_bits[i]),
      .init_phase (init_ph[i*P +: P]),
      .phases_all (phases),
      .row        (row[i]),
      .phase      (phases[i*P +: P]),
      .nxt_msb    (nxt_msb[i])
    );

    assign spins[i]    = phases[i*P + P - 1];
    assign init_msb[i] = init_ph[i*P + P - 1];
  end

endmodule

// File: tb/tb_sync_core_matrix.sv
// Scoreboard bench for sync_core_matrix: directed cases plus randomized runs against a phase model.
module tb_sync_core_matrix;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [15:0] run_cycles = '0;
  logic        busy;
  logic [2:0]  spins;
  logic [23:0] phases;

  always #5 clk = ~clk;

  sync_core_matrix_if #(.N(3), .ADDR_W(3), .DATA_W(8)) bus ();

  sync_core_matrix #(
    .N(3), .NUM_WEIGHTS(5), .PHASE_BITS(8), .BASE_STEP(16), .RUN_BITS(16)
  ) u_dut (
    .clk        (clk),
    .rstn       (rstn),
    .bus        (bus.slave),
    .start      (start),
    .abort      (abort),
    .run_cycles (run_cycles),
    .busy       (busy),
    .spins      (spins),
    .phases     (phases)
  );

  typedef struct {
    logic [2:0]  res;
    logic [23:0] ph;
  } exp_t;

  exp_t sb_q[$];
  int   errors = 0;
  int   checks = 0;
  int   m_code[3];
  int   m_init[3];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int cpl(int code);
    return (code >= 5) ? 0 : code - 2;
  endfunction

  // pairs (0,1),(0,2),(1,2) map to weight slots 0,1,2
  function automatic int pair_slot(int i, int j);
    return (i + j == 1) ? 0 : (i + j == 2) ? 1 : 2;
  endfunction

  function automatic exp_t model(int rc);
    exp_t e;
    int ph[3];
    int nx[3];
    int d, s;
    for (int i = 0; i < 3; i++) ph[i] = m_init[i];
    for (int k = 0; k < rc; k++) begin
      for (int i = 0; i < 3; i++) begin
        s = 16;
        for (int j = 0; j < 3; j++) begin
          if (j == i) continue;
          d = (ph[j] - ph[i]) & 255;
          if (d >= 128) d -= 256;
          s += cpl(m_code[pair_slot(i, j)]) * ((d > 0) ? 1 : (d < 0) ? -1 : 0);
        end
        if (s < 1) s = 1;
        if (s > 127) s = 127;
        nx[i] = (ph[i] + s) & 255;
      end
      for (int i = 0; i < 3; i++) ph[i] = nx[i];
    end
    for (int i = 0; i < 3; i++) begin
      e.res[i]       = (ph[i] >= 128);
      e.ph[i*8 +: 8] = 8'(ph[i]);
    end
    return e;
  endfunction

  always @(negedge clk) begin
    if (rstn && bus.result_valid && bus.result_ready) begin
      if (sb_q.size() == 0) begin
        check("unexpected_result", 32'(bus.result), 32'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("sb_result", 32'(bus.result), 32'(e.res));
        check("sb_phases", 32'(phases), 32'(e.ph));
      end
    end
  end

  task automatic cfg_write(input int a, input int d);
    check("cfg_ready_idle", 32'(bus.cfg_ready), 32'd1);
    bus.cfg_valid = 1'b1;
    bus.cfg_addr  = 3'(a);
    bus.cfg_data  = 8'(d);
    @(posedge clk);
    #1 bus.cfg_valid = 1'b0;
    if (a < 3)      m_code[a] = d & 7;
    else if (a < 6) m_init[a-3] = d & 255;
  endtask

  task automatic setup(input int c0, c1, c2, p0, p1, p2);
    cfg_write(0, c0); cfg_write(1, c1); cfg_write(2, c2);
    cfg_write(3, p0); cfg_write(4, p1); cfg_write(5, p2);
  endtask

  task automatic start_run(input int rc, input bit push);
    if (push) sb_q.push_back(model(rc));
    run_cycles = 16'(rc);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_valid(input int bound);
    int n = 0;
    while (!bus.result_valid && n < bound) begin
      @(posedge clk); #1; n++;
    end
    if (!bus.result_valid) check("timeout_valid", 32'd0, 32'd1);
  endtask

  task automatic wait_idle(input int bound);
    int n = 0;
    while (busy && n < bound) begin
      @(posedge clk); #1; n++;
    end
    if (busy) check("timeout_idle", 32'd1, 32'd0);
  endtask

  task automatic reset_outputs_check();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_cfg_ready", 32'(bus.cfg_ready), 32'd1);
    check("rst_phases", 32'(phases), 32'd0);
    check("rst_spins", 32'(spins), 32'd0);
    check("rst_result", 32'(bus.result), 32'd0);
    check("rst_result_valid", 32'(bus.result_valid), 32'd0);
  endtask

  initial begin
    exp_t       e;
    logic [2:0] r_hold;
    logic [23:0] p_hold;
    int         seen;
    bus.cfg_valid    = 1'b0;
    bus.cfg_addr     = '0;
    bus.cfg_data     = '0;
    bus.result_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin m_code[i] = 0; m_init[i] = 0; end

    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;
    reset_outputs_check();

    // reset asserted in the middle of a run
    setup(2, 2, 2, 0, 64, 128);
    start_run(100, 1'b0);
    repeat (5) @(posedge clk);
    #1 rstn = 1'b0;
    #2 reset_outputs_check();
    for (int i = 0; i < 3; i++) begin m_code[i] = 0; m_init[i] = 0; end
    @(posedge clk);
    #1 rstn = 1'b1;

    // mutual pull closes the gap on w01=+2
    setup(4, 2, 2, 0, 16, 0);
    start_run(4, 1'b1);
    wait_valid(20);
    check("t3_phases", 32'(phases), 32'({8'd64, 8'd72, 8'd72}));
    check("t3_result", 32'(bus.result), 32'd0);
    wait_idle(5);

    // zero coupling: free-running at base step
    setup(2, 2, 2, 0, 64, 128);
    start_run(4, 1'b1);
    wait_valid(20);
    check("t2_phases", 32'(phases), 32'({8'd192, 8'd128, 8'd64}));
    check("t2_result", 32'(bus.result), 32'b110);
    check("t2_result_valid", 32'(bus.result_valid), 32'd1);
    wait_idle(5);

    // abort after ten updates
    start_run(100, 1'b0);
    repeat (10) @(posedge clk);
    #1 abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    check("abort_busy", 32'(busy), 32'd0);
    e = model(10);
    check("abort_phases_frozen", 32'(phases), 32'(e.ph));
    seen = 0;
    repeat (5) begin
      @(posedge clk); #1;
      if (bus.result_valid) seen++;
    end
    check("abort_no_valid", 32'(seen), 32'd0);
    check("abort_result_kept", 32'(bus.result), 32'b110);
    check("abort_phases_still", 32'(phases), 32'(e.ph));

    // consumer stalls in DONE; start and cfg writes must be ignored
    setup(0, 3, 4, 10, 200, 90);
    bus.result_ready = 1'b0;
    start_run(6, 1'b1);
    wait_valid(20);
    r_hold = bus.result;
    p_hold = phases;
    for (int k = 0; k < 10; k++) begin
      check("hold_valid", 32'(bus.result_valid), 32'd1);
      check("hold_result", 32'(bus.result), 32'(r_hold));
      check("hold_phases", 32'(phases), 32'(p_hold));
      check("hold_cfg_ready", 32'(bus.cfg_ready), 32'd0);
      start = (k == 3);
      bus.cfg_valid = (k == 4);
      bus.cfg_addr  = 3'd0;
      bus.cfg_data  = 8'd4;
      @(posedge clk); #1;
    end
    start = 1'b0;
    bus.cfg_valid = 1'b0;
    bus.result_ready = 1'b1;
    wait_idle(5);
    check("hold_back_idle", 32'(busy), 32'd0);
    start_run(5, 1'b1);
    wait_valid(20);
    wait_idle(5);

    // out-of-range address and oversize code behave as zero coupling
    cfg_write(6, 4);
    cfg_write(7, 4);
    setup(7, 7, 7, 0, 64, 128);
    start_run(4, 1'b1);
    wait_valid(20);
    check("t6_phases", 32'(phases), 32'({8'd192, 8'd128, 8'd64}));
    check("t6_result", 32'(bus.result), 32'b110);
    wait_idle(5);

    // zero-length run returns init MSBs
    setup(1, 4, 0, 130, 5, 255);
    start_run(0, 1'b1);
    wait_valid(5);
    check("rc0_result", 32'(bus.result), 32'b101);
    wait_idle(5);

    for (int it = 0; it < 12; it++) begin
      setup($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
            $urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255));
      start_run($urandom_range(0, 20), 1'b1);
      wait_valid(40);
      wait_idle(5);
    end

    repeat (3) @(posedge clk);
    #1 check("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
